// File: rtl/video_scan_doubler.sv
`default_nettype none
// ============================================================================
//  Module   : video_scan_doubler
//  Purpose  : Line doubler. Captures each 1-bit scanline, with its sync
//             timing, into a ping-pong buffer and replays it twice at
//             double pixel rate (15.7 kHz PET timing -> 31.5 kHz VGA-class).
//  Revision : 1.0  initial release
// ============================================================================
module video_scan_doubler #(
   parameter int MAX_PIXELS = 1024,
   parameter int CNT_WIDTH  = 11
) (
   input  logic sys_clock_i,
   input  logic reset_n_i,
   input  logic pixel_clk_en_i,
   input  logic out_clk_en_i,
   input  logic h_sync_i,
   input  logic v_sync_i,
   input  logic video_i,
   output logic vga_h_sync_o,
   output logic vga_v_sync_o,
   output logic vga_video_o
);

   // Buffer addressing assumes MAX_PIXELS is a power of two.
   localparam int                   ADDR_W     = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1;
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   C_ADDR_ONE = (CNT_WIDTH+1)'(1);
   localparam logic [CNT_WIDTH:0]   C_DEPTH    = (CNT_WIDTH+1)'(MAX_PIXELS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2
   } state_t;

   // Capture side
   logic                 r_hs_prev;
   logic [CNT_WIDTH-1:0] r_p_cnt;
   logic [CNT_WIDTH-1:0] r_s_cnt;
   logic [CNT_WIDTH-1:0] r_h_period;
   logic [CNT_WIDTH-1:0] r_h_sync_len;
   logic                 r_wr_bank;
   logic                 r_rd_bank;
   logic                 r_line_buf [0:1][0:MAX_PIXELS-1];

   logic                 w_edge;
   logic [CNT_WIDTH-1:0] w_p_next;
   logic [CNT_WIDTH-1:0] w_s_next;
   logic [CNT_WIDTH:0]   w_wr_addr;
   logic                 w_wr_en;
   logic                 w_wr_sel;

   // Replay side
   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_out_x;
   logic [CNT_WIDTH-1:0] w_out_x_nxt;
   logic                 w_pass_start;
   logic                 w_last_x;
   logic                 r_vs_pass;
   logic                 w_rd_pix;

   assign w_edge   = pixel_clk_en_i & h_sync_i & ~r_hs_prev;
   assign w_p_next = (r_p_cnt == C_CNT_MAX) ? C_CNT_MAX : (r_p_cnt + C_CNT_ONE);
   assign w_s_next = (r_s_cnt == C_CNT_MAX) ? C_CNT_MAX : (r_s_cnt + C_CNT_ONE);

   // The pixel on the edge tick is the first pixel of the new line, so it
   // goes into the bank that is about to become the write bank. The bank
   // that is about to be replayed is therefore never touched.
   assign w_wr_addr = w_edge ? '0 : ({1'b0, r_p_cnt} + C_ADDR_ONE);
   assign w_wr_en   = pixel_clk_en_i & (w_wr_addr < C_DEPTH);
   assign w_wr_sel  = w_edge ? ~r_wr_bank : r_wr_bank;

   // Line period / sync width measurement and bank swapping.
   always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_hs_prev    <= 1'b0;
         r_p_cnt      <= '0;
         r_s_cnt      <= '0;
         r_h_period   <= '0;
         r_h_sync_len <= '0;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
      end else if (pixel_clk_en_i) begin
         r_hs_prev <= h_sync_i;
         if (w_edge) begin
            r_h_period   <= w_p_next;
            r_p_cnt      <= '0;
            r_h_sync_len <= r_s_cnt;
            r_s_cnt      <= C_CNT_ONE;
            r_rd_bank    <= r_wr_bank;
            r_wr_bank    <= ~r_wr_bank;
         end else begin
            r_p_cnt <= w_p_next;
            if (h_sync_i) begin
               r_s_cnt <= w_s_next;
            end
         end
      end
   end

   // Line buffer write port; contents are deliberately not reset.
   always_ff @(posedge sys_clock_i) begin
      if (w_wr_en) begin
         r_line_buf[w_wr_sel][w_wr_addr[ADDR_W-1:0]] <= video_i;
      end
   end

   assign w_last_x = (r_out_x == (r_h_period - C_CNT_ONE));

   // Replay state register.
   always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
         r_out_x <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out_x <= w_out_x_nxt;
      end
   end

   // Replay next-state: an input edge always restarts the first pass, and
   // takes priority over any out-tick advance on the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_out_x_nxt  = r_out_x;
      w_pass_start = 1'b0;
      if (w_edge) begin
         if (r_h_period != '0) begin
            w_state_nxt  = ST_PASS1;
            w_out_x_nxt  = '0;
            w_pass_start = 1'b1;
         end
      end else if (out_clk_en_i) begin
         case (r_state)
            ST_PASS1: begin
               if (w_last_x) begin
                  w_state_nxt  = ST_PASS2;
                  w_out_x_nxt  = '0;
                  w_pass_start = 1'b1;
               end else begin
                  w_out_x_nxt = r_out_x + C_CNT_ONE;
               end
            end
            ST_PASS2: begin
               if (w_last_x) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_out_x_nxt = r_out_x + C_CNT_ONE;
               end
            end
            ST_IDLE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Vertical sync is sampled once per pass so it only changes on pass boundaries.
   always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_vs_pass <= 1'b0;
      end else if (w_pass_start) begin
         r_vs_pass <= v_sync_i;
      end
   end

   assign w_rd_pix = r_line_buf[r_rd_bank][r_out_x[ADDR_W-1:0]];

   // Registered outputs; pixels past the buffer depth replay as dark.
   always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         vga_h_sync_o <= 1'b0;
         vga_v_sync_o <= 1'b0;
         vga_video_o  <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         vga_h_sync_o <= 1'b0;
         vga_v_sync_o <= 1'b0;
         vga_video_o  <= 1'b0;
      end else begin
         vga_h_sync_o <= (r_out_x < r_h_sync_len);
         vga_v_sync_o <= r_vs_pass;
         vga_video_o  <= ({1'b0, r_out_x} < C_DEPTH) ? w_rd_pix : 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_video_scan_doubler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_scan_doubler
//  Purpose  : Bench for video_scan_doubler. Line-level stimulus table with
//             per-pass output totals, a reset sequence, random lines, and a
//             line-replay reference model checked every clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_video_scan_doubler;

   localparam int MAXP = 1024;

   logic sys_clock_i = 1'b0;
   logic reset_n_i;
   logic pixel_clk_en_i;
   logic out_clk_en_i;
   logic h_sync_i;
   logic v_sync_i;
   logic video_i;
   logic vga_h_sync_o;
   logic vga_v_sync_o;
   logic vga_video_o;

   video_scan_doubler #(.MAX_PIXELS(MAXP), .CNT_WIDTH(11)) dut (
      .sys_clock_i    (sys_clock_i),
      .reset_n_i      (reset_n_i),
      .pixel_clk_en_i (pixel_clk_en_i),
      .out_clk_en_i   (out_clk_en_i),
      .h_sync_i       (h_sync_i),
      .v_sync_i       (v_sync_i),
      .video_i        (video_i),
      .vga_h_sync_o   (vga_h_sync_o),
      .vga_v_sync_o   (vga_v_sync_o),
      .vga_video_o    (vga_video_o)
   );

   always #5 sys_clock_i = ~sys_clock_i;

   // One input line plus the expected per-pass totals of the output it carries.
   typedef struct {
      int len;  int hs_len; int lo; int hi; int vs_tick;
      int e_hs0; int e_vid0; int e_vs0;
      int e_hs1; int e_vid1; int e_vs1;
   } line_t;

   localparam int NT = 10;
   line_t tbl [NT];

   int checks   = 0;
   int failures = 0;

   // Reference model: previous captured line is replayed from its edge.
   int cyc = 0;
   bit vs_hist[$];
   bit cur_q[$];
   int cur_hs;
   bit seen_edge;
   bit ref_valid;
   int ref_c, ref_L, ref_S;
   bit ref_data[$];
   int ln = -1;
   int tbl_base = -1;
   int cnt_hs[2], cnt_vid[2], cnt_vs[2];
   int mism_hs, mism_vid, mism_vs;
   int first_cyc;
   logic [2:0] first_got, first_exp;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic chk_mism(input string name, input int n);
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL %s: %0d cycles differ from model (first at cycle %0d: got hs/vid/vs=%b, required %b)",
                  name, n, first_cyc, first_got, first_exp);
      end
   endtask

   task automatic model_check(input int m);
      int  d, p, k, two_l;
      bit  e_hs, e_vid, e_vs;
      logic [2:0] got;
      e_hs = 0; e_vid = 0; e_vs = 0; p = 2; d = 0; k = 0;
      if (ref_valid) begin
         two_l = 2 * ref_L;
         d = m - ref_c - 1;
         p = d / two_l;
         k = (d % two_l) / 2;
         if (p < 2) begin
            e_hs  = (k < ref_S);
            e_vid = (k < MAXP) ? ref_data[k] : 1'b0;
            e_vs  = (p == 0) ? vs_hist[ref_c] : vs_hist[ref_c + two_l];
         end
      end
      got = {vga_h_sync_o, vga_video_o, vga_v_sync_o};
      if (got !== {e_hs, e_vid, e_vs}) begin
         if (mism_hs + mism_vid + mism_vs == 0) begin
            first_cyc = m; first_got = got; first_exp = {e_hs, e_vid, e_vs};
         end
         if (vga_h_sync_o !== e_hs)  mism_hs++;
         if (vga_video_o  !== e_vid) mism_vid++;
         if (vga_v_sync_o !== e_vs)  mism_vs++;
      end
      if (!ref_valid) begin
         cnt_hs[0]  += int'(vga_h_sync_o === 1'b1);
         cnt_vid[0] += int'(vga_video_o === 1'b1);
         cnt_vs[0]  += int'(vga_v_sync_o === 1'b1);
      end else if (p < 2 && (d % 2) == 0) begin
         cnt_hs[p]  += int'(vga_h_sync_o === 1'b1);
         cnt_vid[p] += int'(vga_video_o === 1'b1);
         cnt_vs[p]  += int'(vga_v_sync_o === 1'b1);
      end
   endtask

   task automatic finalize_line();
      int idx;
      chk_mism($sformatf("model_hs line %0d", ln), mism_hs);
      chk_mism($sformatf("model_video line %0d", ln), mism_vid);
      chk_mism($sformatf("model_vs line %0d", ln), mism_vs);
      idx = ln - tbl_base;
      if (tbl_base >= 0 && idx >= 0 && idx < NT) begin
         chk($sformatf("tbl%0d pass1 hsync ticks", idx), cnt_hs[0],  tbl[idx].e_hs0);
         chk($sformatf("tbl%0d pass1 video ticks", idx), cnt_vid[0], tbl[idx].e_vid0);
         chk($sformatf("tbl%0d pass1 vsync ticks", idx), cnt_vs[0],  tbl[idx].e_vs0);
         chk($sformatf("tbl%0d pass2 hsync ticks", idx), cnt_hs[1],  tbl[idx].e_hs1);
         chk($sformatf("tbl%0d pass2 video ticks", idx), cnt_vid[1], tbl[idx].e_vid1);
         chk($sformatf("tbl%0d pass2 vsync ticks", idx), cnt_vs[1],  tbl[idx].e_vs1);
      end
      mism_hs = 0; mism_vid = 0; mism_vs = 0;
      for (int i = 0; i < 2; i++) begin
         cnt_hs[i] = 0; cnt_vid[i] = 0; cnt_vs[i] = 0;
      end
   endtask

   task automatic model_edge(input int m);
      finalize_line();
      ln++;
      ref_valid = seen_edge;
      ref_c     = m;
      ref_L     = cur_q.size();
      ref_S     = (cur_hs > 2047) ? 2047 : cur_hs;
      ref_data  = cur_q;
      cur_q.delete();
      cur_hs    = 0;
      seen_edge = 1'b1;
   endtask

   task automatic model_reset();
      ref_valid = 1'b0;
      seen_edge = 1'b0;
      cur_q.delete();
      cur_hs = 0;
   endtask

   task automatic cycle(input bit edge_now);
      pixel_clk_en_i = (cyc % 4 == 0);
      out_clk_en_i   = (cyc % 2 == 0);
      vs_hist.push_back(v_sync_i);
      @(posedge sys_clock_i);
      #1;
      model_check(cyc);
      if (edge_now) model_edge(cyc);
      cyc++;
   endtask

   task automatic do_tick(input bit hs, input bit vid, input bit vs, input bit edge_now);
      h_sync_i = hs; video_i = vid; v_sync_i = vs;
      cycle(edge_now);
      cur_q.push_back(vid);
      if (hs) cur_hs++;
      repeat (3) cycle(1'b0);
   endtask

   task automatic run_line(input line_t r, input bit rnd);
      bit vid;
      for (int t = 0; t < r.len; t++) begin
         vid = rnd ? bit'($urandom_range(0, 1)) : bit'(t >= r.lo && t <= r.hi);
         do_tick(bit'(t < r.hs_len), vid, bit'(r.vs_tick >= 0 && t >= r.vs_tick), bit'(t == 0));
      end
   endtask

   initial begin
      line_t r;
      //          len  hs   lo   hi   vs    hs0 vid0 vs0  hs1 vid1  vs1
      tbl[0] = '{1024, 96, 200, 207,  -1,    0,   0,  0,   0,   0,    0};
      tbl[1] = '{1024, 96, 200, 207,  -1,   96,   8,  0,  96,   8,    0};
      tbl[2] = '{1024, 96, 200, 207,  -1,   96,   8,  0,  96,   8,    0};
      tbl[3] = '{ 600, 60,   0, 599,  -1,   96,   8,  0,  96,   0,    0};
      tbl[4] = '{ 600, 60,   1,   0,  -1,   60, 600,  0,  60, 600,    0};
      tbl[5] = '{ 600, 60,   0, 599,  -1,   60,   0,  0,  60,   0,    0};
      tbl[6] = '{ 600, 60,   1,   0,  -1,   60, 600,  0,  60, 600,    0};
      tbl[7] = '{1100, 96,   0,1099,  -1,   60,   0,  0,  60,   0,    0};
      tbl[8] = '{1100, 96,   1,   0, 200,   96,1024,  0,  96,1024, 1100};
      tbl[9] = '{ 400, 40,   1,   0,  -1,   96,   0,  0,   0,   0,    0};

      reset_n_i = 1'b0; pixel_clk_en_i = 1'b0; out_clk_en_i = 1'b0;
      h_sync_i = 1'b0; v_sync_i = 1'b0; video_i = 1'b0;
      model_reset();
      repeat (3) do_tick(0, 0, 0, 0);
      chk("reset outputs", int'({vga_h_sync_o, vga_video_o, vga_v_sync_o}), 0);
      reset_n_i = 1'b1;
      repeat (5) do_tick(0, 0, 0, 0);

      // Two short lit lines, then reset in the middle of a replay pass.
      r = '{200, 20, 0, 199, -1, 0, 0, 0, 0, 0, 0};
      run_line(r, 1'b0);
      run_line(r, 1'b0);
      do_tick(1, 1, 0, 1);
      repeat (4) do_tick(1, 1, 0, 0);
      chk("hsync active before reset", int'(vga_h_sync_o), 1);
      chk("video active before reset", int'(vga_video_o), 1);
      reset_n_i = 1'b0;
      #1;
      chk("async reset outputs", int'({vga_h_sync_o, vga_video_o, vga_v_sync_o}), 0);
      finalize_line();
      model_reset();
      repeat (4) do_tick(0, 0, 0, 0);
      reset_n_i = 1'b1;
      repeat (6) do_tick(0, 0, 0, 0);

      tbl_base = ln + 1;
      for (int i = 0; i < NT; i++) run_line(tbl[i], 1'b0);

      for (int i = 0; i < 6; i++) begin
         r.len     = int'($urandom_range(150, 500));
         r.hs_len  = int'($urandom_range(4, 60));
         r.lo      = 0;
         r.hi      = 0;
         r.vs_tick = int'($urandom_range(0, r.len)) - 1;
         run_line(r, 1'b1);
      end
      r = '{300, 30, 1, 0, -1, 0, 0, 0, 0, 0, 0};
      run_line(r, 1'b0);
      finalize_line();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_scan_doubler.md
# video_scan_doubler

Line-doubling stage directly downstream of `video`. It captures the 1-bit pixel stream and sync pulses from the dot generator into a ping-pong line buffer. Each captured scanline is replayed twice at double pixel rate, converting ~15.7 kHz PET timing to ~31.5 kHz VGA-class timing. Inputs are polarity-normalized (active-high) upstream; output polarity is adjusted by the board-level mux.

## Interface
Parameters:
- `MAX_PIXELS`, 1024, line buffer depth per bank (pixel ticks per input line).
- `CNT_WIDTH`, 11, width of the period and sync counters; must satisfy 2^CNT_WIDTH > MAX_PIXELS.

Ports:
- `sys_clock_i`  in  1  single system clock; all state is on its rising edge.
- `reset_n_i`  in  1  reset, asynchronous and active-low.
- `pixel_clk_en_i`  in  1  input pixel-rate enable, same enable that drives the dot generator.
- `out_clk_en_i`  in  1  output pixel enable at exactly 2× the `pixel_clk_en_i` rate.
- `h_sync_i`  in  1  horizontal sync, active-high.
- `v_sync_i`  in  1  vertical sync, active-high.
- `video_i`  in  1  pixel, 1 = lit.
- `vga_h_sync_o`  out  1  doubled horizontal sync, active-high, registered.
- `vga_v_sync_o`  out  1  vertical sync re-timed to output lines, registered.
- `vga_video_o`  out  1  doubled pixel, registered.

## Operation
- **Capture.** All capture logic is sampled only on `pixel_clk_en_i`.
  - `hs_prev` holds the previous `h_sync_i` sample.
  - A rising edge (`edge`) is `h_sync_i & !hs_prev` on an enable cycle.
- **Period counter `p_cnt`.**
  - On `edge`: `h_period <= p_cnt + 1` (saturating at 2^CNT_WIDTH−1) and `p_cnt <= 0`.
  - Otherwise: `p_cnt <= p_cnt + 1`, saturating.
- **Sync counter `s_cnt`.**
  - On `edge`: `h_sync_len <= s_cnt` and `s_cnt <= 1`.
  - Otherwise: `s_cnt` increments while `h_sync_i` is high, saturating.
- **Buffer write.**
  - Each enable writes `video_i` to `buf[wr_bank][addr]`, where `addr = 0` on `edge`, else `p_cnt + 1`.
  - The write is suppressed when `addr >= MAX_PIXELS`.
- **Bank swap.** On `edge`, `rd_bank <= wr_bank` and `wr_bank <= !wr_bank`. The bank being read is therefore never the bank being written.
- **Output FSM states:**
  - `IDLE`: all outputs 0.
  - `PASS1`, `PASS2`: active output passes.
- **`edge` transitions.**
  - `edge` with latched `h_period != 0` → `PASS1`, `out_x <= 0`, from any state.
  - If `h_period == 0` (first line after reset), stay in `IDLE`.
- **Advancing `out_x`.** `out_x` advances on `out_clk_en_i` only.
  - At `out_x == h_period − 1`: `PASS1` → `PASS2` with `out_x <= 0`; `PASS2` → `IDLE`.
  - An input edge arriving during `PASS1` or `PASS2` aborts the pass and restarts `PASS1`. This handles jitter and a shortened line.
- **Per-pass outputs** (in `PASS1`/`PASS2`, registered, updated every sys clock):
  - `vga_h_sync_o = (out_x < h_sync_len)`
  - `vga_video_o = (out_x < MAX_PIXELS) ? buf[rd_bank][out_x] : 0`
  - `vga_v_sync_o` latches `v_sync_i` at each pass start, i.e. the cycle `out_x` is set to 0, and holds it for the pass.
- **Width and duration.** Identical counts at 2× rate give each output pass half the input line duration. Sync width is likewise halved.

## Timing
- **Reset.** All outputs are 0. `p_cnt`, `s_cnt`, `h_period`, `h_sync_len`, `out_x`, `hs_prev` and both bank selects are 0; the FSM is in `IDLE`. Buffer RAM contents are not reset.
- **Reset mid-operation.** Outputs drop to 0 immediately (asynchronously). The first line after reset produces no output.
- **Latency.** The pixel written at address *k* of line *n* appears on `vga_video_o` during line *n+1*: once in `PASS1` and once in `PASS2`. It appears one sys clock after the `out_clk_en_i` that sets `out_x = k`.
- **Simultaneous events.**
  - `edge` on the same cycle as `out_x == h_period − 1`: `edge` wins → `PASS1`, `out_x = 0`.
  - `edge` and `out_clk_en_i` on the same cycle: `out_x = 0`, no increment.
- **Saturation.** Lines longer than `MAX_PIXELS` replay buffer pixels up to `MAX_PIXELS − 1`, then 0 until the pass ends.
- **No RAM read-during-write conflict.** Banks differ whenever a pass is active.

## Test plan
- **Reset idle.** Assert `reset_n_i = 0` mid-pass → all outputs 0 the same cycle. After release, feed one line of 1024 ticks → outputs stay 0 during that line.
- **Basic doubling.** Lines of 1024 pixel ticks with `h_sync_i` high for 96 ticks and `video_i` = 1 at ticks 200–207 only.
  - From the second line on, each input line yields two passes of 1024 out ticks.
  - `vga_h_sync_o` is high for 96 out ticks per pass.
  - `vga_video_o` is high at `out_x` 200–207 in both passes.
- **Bank isolation.** Alternate lines are all-1 / all-0 → each output pair shows the previous line's constant, with no mixing within a pass.
- **Short/early hsync.** Line of 1024 ticks, then an edge after only 600 ticks → the pass in progress aborts. `PASS1` restarts, `h_period` becomes 600, and the following passes are 600 out ticks long.
- **Saturation.** 1100-tick line with `video_i` = 1 throughout → `vga_video_o` is 1 for `out_x` 0–1023 and 0 for 1024–1099 in each pass.
- **Vsync re-timing.** `v_sync_i` rises mid-`PASS1` → `vga_v_sync_o` stays 0 until `PASS2` starts, then goes 1 for the full pass.
